// File: rtl/register_dump_unit_pkg.sv
// Shared types and constants for the register dump path (FSM encoding, byte geometry, sync byte).
package register_dump_unit_pkg;

  localparam int NB_BYTE          = 8;
  localparam int NB_DATA_DEFAULT  = 32;
  localparam int BYTES_PER_WORD   = NB_DATA_DEFAULT / NB_BYTE;
  localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4,
    ST_HEADER = 3'd5
  } dump_state_e;

endpackage

// File: rtl/register_dump_unit_word_serializer.sv
// Word-to-byte serializer: holds one word (or a lone header byte) and emits it MSB first
// over a valid/ready stream, flagging the transfer of the final byte back to the controller.
module register_dump_unit_word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = register_dump_unit_pkg::NB_BYTE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_word_i,
  input  logic               load_hdr_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic [NB_BYTE-1:0] hdr_byte_i,
  input  logic               tx_ready_i,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic               tx_valid_o,
  output logic               last_xfer_o
);

  localparam int WORD_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(WORD_BYTES - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               xfer_s;
  logic               last_s;

  // Next-state for shift register, byte counter and valid; a header load sits at the
  // last count so its single byte retires like the tail of a word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    xfer_s  = valid_q & tx_ready_i;
    last_s  = xfer_s & (cnt_q == LAST_CNT);
    if (load_word_i) begin
      shift_d = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (load_hdr_i) begin
      shift_d = '0;
      shift_d[NB_DATA-1 -: NB_BYTE] = hdr_byte_i;
      cnt_d   = LAST_CNT;
      valid_d = 1'b1;
    end else if (last_s) begin
      valid_d = 1'b0;
    end else if (xfer_s) begin
      shift_d = shift_q << NB_BYTE;
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      valid_d = valid_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o   = shift_q[NB_DATA-1 -: NB_BYTE];
  assign tx_valid_o  = valid_q;
  assign last_xfer_o = last_s;

endmodule

// File: rtl/register_dump_unit.sv
// register_dump_unit: steps every register through the bank read port and streams its bytes
// MSB first toward the debug UART. Optional macro REG_DUMP_HEADER_EN prepends one sync byte.
module register_dump_unit #(
  parameter int NB_DATA     = 32,
  parameter int N_REGISTERS = 32,
  parameter int NB_REGISTER = 5,
  parameter int NB_BYTE     = register_dump_unit_pkg::NB_BYTE
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_dump_start,
  input  logic [NB_DATA-1:0]     i_reg_data,
  output logic [NB_REGISTER-1:0] o_reg_sel,
  output logic                   o_reg_read_en,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  import register_dump_unit_pkg::*;

  localparam logic [NB_REGISTER-1:0] LAST_REG = NB_REGISTER'(N_REGISTERS - 1);
  localparam logic [NB_REGISTER-1:0] IDX_ONE  = NB_REGISTER'(1);

  dump_state_e            state_q, state_d;
  logic [NB_REGISTER-1:0] index_q, index_d;
  logic                   busy_q;
  logic                   read_en_q;
  logic                   done_q;
  logic                   load_word_s;
  logic                   load_hdr_s;
  logic                   last_xfer_s;

  // Dump sequencer: start is only honoured in IDLE, so a held start re-arms after DONE.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    load_word_s = 1'b0;
    load_hdr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          index_d = '0;
`ifdef REG_DUMP_HEADER_EN
          load_hdr_s = 1'b1;
          state_d    = ST_HEADER;
`else
          state_d    = ST_SELECT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (last_xfer_s) begin
          state_d = ST_SELECT;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_SELECT: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_word_s = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (last_xfer_s && (index_q == LAST_REG)) begin
          state_d = ST_DONE;
        end else if (last_xfer_s) begin
          index_d = index_q + IDX_ONE;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      busy_q    <= 1'b0;
      read_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      busy_q    <= (state_d != ST_IDLE);
      read_en_q <= (state_d == ST_SELECT) || (state_d == ST_LOAD);
      done_q    <= (state_d == ST_DONE);
    end
  end

  register_dump_unit_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .clk_i       (i_clock),
    .rst_i       (i_reset),
    .load_word_i (load_word_s),
    .load_hdr_i  (load_hdr_s),
    .word_i      (i_reg_data),
    .hdr_byte_i  (NB_BYTE'(DUMP_HEADER_BYTE)),
    .tx_ready_i  (i_tx_ready),
    .tx_data_o   (o_tx_data),
    .tx_valid_o  (o_tx_valid),
    .last_xfer_o (last_xfer_s)
  );

  assign o_reg_sel     = index_q;
  assign o_reg_read_en = read_en_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: bank preloaded with 32'hC0DE0000|i, byte stream
// collected and compared against hand-derived values; honours REG_DUMP_HEADER_EN if defined.
module tb_register_dump_unit;

`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL     = 128 + HDR;
  localparam int STALL_LEN = 5;
  localparam int TIMEOUT   = 800;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] reg_data = 32'h0;
  logic [4:0]  reg_sel;
  logic        reg_read_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] bank [32];

  int tests_run    = 0;
  int tests_failed = 0;

  register_dump_unit dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_dump_start  (start),
    .i_reg_data    (reg_data),
    .o_reg_sel     (reg_sel),
    .o_reg_read_en (reg_read_en),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clock = ~clock;

  // Register bank with one-cycle read latency.
  always @(posedge clock) begin
    if (reg_read_en) reg_data <= bank[reg_sel];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    int          idx;
    logic [31:0] w;
    if (HDR == 1 && n == 0) return 8'hA5;
    idx = n - HDR;
    w = 32'hC0DE0000 | 32'(idx / 4);
    return w[31 - 8 * (idx % 4) -: 8];
  endfunction

  // Starts a dump at the current negedge and follows it cycle by cycle.
  task automatic run_dump(input string tag, input int stall_idx, input int restart_idx,
                          input int abort_idx, input bit hold_start, input int exp_done_cyc);
    int nbytes, ndone, first_valid, done_cyc, sel_cycles, stall_left, cyc;
    bit finished, restarted;
    nbytes = 0; ndone = 0; first_valid = -1; done_cyc = -1; sel_cycles = 0;
    stall_left = STALL_LEN; finished = 1'b0; restarted = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = hold_start;
    cyc = 0;
    while (!finished && cyc < TIMEOUT) begin
      tx_ready = 1'b1;
      if (tx_valid && nbytes == stall_idx && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
        check_eq({tag, " stall valid"}, int'(tx_valid), 1);
        check_eq({tag, " stall data"}, int'(tx_data), int'(exp_byte(nbytes)));
      end
      if (!restarted && tx_valid && nbytes == restart_idx) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = hold_start;
      end
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (reg_read_en) begin
        sel_cycles++;
        check_eq({tag, " reg_sel"}, int'(reg_sel), (nbytes - HDR) / 4);
      end
      if (tx_valid && tx_ready) begin
        check_eq({tag, " byte"}, int'(tx_data), int'(exp_byte(nbytes)));
        nbytes++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((abort_idx >= 0 && nbytes == abort_idx) || done) begin
        finished = 1'b1;
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    check_eq({tag, " finished"}, int'(finished), 1);
    if (abort_idx < 0) begin
      if (!hold_start) begin
        start = 1'b0;
        repeat (4) begin
          @(negedge clock);
          if (done) ndone++;
        end
        check_eq({tag, " idle busy"}, int'(busy), 0);
      end
      check_eq({tag, " byte count"}, nbytes, TOTAL);
      check_eq({tag, " done pulses"}, ndone, 1);
      check_eq({tag, " done cycle"}, done_cyc, exp_done_cyc);
      check_eq({tag, " first valid"}, first_valid, (HDR == 1) ? 0 : 2);
      check_eq({tag, " read cycles"}, sel_cycles, 64);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'hC0DE0000 | 32'(i);

    repeat (3) @(negedge clock);
    check_eq("reset valid", int'(tx_valid), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset read_en", int'(reg_read_en), 0);
    check_eq("reset reg_sel", int'(reg_sel), 0);
    check_eq("reset tx_data", int'(tx_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_dump("basic", -1, -1, -1, 1'b0, 192 + HDR);
    run_dump("stall", 14 + HDR, -1, -1, 1'b0, 192 + HDR + STALL_LEN);
    run_dump("restart", -1, 40, -1, 1'b0, 192 + HDR);

    run_dump("abort", -1, -1, 50, 1'b0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst valid", int'(tx_valid), 0);
    check_eq("midrst busy", int'(busy), 0);
    check_eq("midrst reg_sel", int'(reg_sel), 0);
    check_eq("midrst read_en", int'(reg_read_en), 0);
    check_eq("midrst tx_data", int'(tx_data), 0);
    reset = 1'b0;
    @(negedge clock);
    run_dump("after rst", -1, -1, -1, 1'b0, 192 + HDR);

    run_dump("hold", -1, -1, -1, 1'b1, 192 + HDR);
    check_eq("hold done busy", int'(busy), 1);
    @(negedge clock);
    check_eq("hold idle busy", int'(busy), 0);
    @(negedge clock);
    start = 1'b0;
    check_eq("hold rearm busy", int'(busy), 1);
    check_eq("hold rearm sel", int'(reg_sel), 0);
    for (int i = 0; i < 8 && !tx_valid; i++) @(negedge clock);
    check_eq("hold second valid", int'(tx_valid), 1);
    check_eq("hold second byte", int'(tx_data), int'(exp_byte(0)));
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
